// File: rtl/pool2x2_stream.sv
// Streaming 2x2 average pooling of a row-major m x m signed feature map.
// Horizontal pair sums of even rows wait in a half-row line buffer until the odd row completes each window.
module pool2x2_stream #(
  parameter int m = 6,
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic                in_valid,
  input  logic signed [W-1:0] in_data,
  output logic                out_valid,
  output logic signed [W-1:0] out_data,
  output logic                done
);

  localparam int CW = (m > 2) ? $clog2(m) : 1;
  localparam int LW = (m > 2) ? $clog2(m / 2) : 1;

  logic [CW-1:0]       r;
  logic [CW-1:0]       c;
  logic signed [W-1:0] hold;
  logic signed [W:0]   lb [m/2];

  logic                accept;
  logic                rLast;
  logic                cLast;
  logic [LW-1:0]       lbIdx;
  logic signed [W:0]   pairSum;
  logic signed [W+1:0] winSum;

  assign accept  = enable && !clear && in_valid;
  assign rLast   = (r == CW'(m - 1));
  assign cLast   = (c == CW'(m - 1));
  assign lbIdx   = LW'(c >> 1);
  assign pairSum = (W+1)'(hold) + (W+1)'(in_data);
  // Full window sum is two bits wider than a sample so four extremes cannot wrap.
  assign winSum  = (W+2)'(lb[lbIdx]) + (W+2)'(hold) + (W+2)'(in_data);

  // Counters, held left sample and the registered pooled output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r         <= '0;
      c         <= '0;
      hold      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      if (enable) begin
        if (clear) begin
          r    <= '0;
          c    <= '0;
          hold <= '0;
        end else if (in_valid) begin
          if (!c[0]) hold <= in_data;
          if (r[0] && c[0]) begin
            out_valid <= 1'b1;
            out_data  <= W'(winSum >>> 2);
            done      <= rLast && cLast;
          end
          if (cLast) begin
            c <= '0;
            r <= rLast ? '0 : r + 1'b1;
          end else begin
            c <= c + 1'b1;
          end
        end
      end
    end
  end

  // Every entry is rewritten on an even row before the odd row reads it, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept && !r[0] && c[0]) lb[lbIdx] <= pairSum;
  end

endmodule

// File: tb/tb_pool2x2_stream.sv
// Scoreboard bench for pool2x2_stream: an m=6 and an m=2 instance checked against a direct 2x2 window average model.
module tb_pool2x2_stream;

  typedef struct {
    int data;
    bit last;
  } exp_t;

  logic               clk;
  logic               reset;
  logic               enable;
  logic               clear;
  logic               in_valid6;
  logic signed [15:0] in_data6;
  logic               out_valid6;
  logic signed [15:0] out_data6;
  logic               done6;
  logic               in_valid2;
  logic signed [15:0] in_data2;
  logic               out_valid2;
  logic signed [15:0] out_data2;
  logic               done2;

  exp_t q6[$];
  exp_t q2[$];
  int   pix6[36];
  int   total;
  int   bad;
  logic enPrev;

  pool2x2_stream #(.m(6), .W(16)) u6 (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .in_valid(in_valid6), .in_data(in_data6),
    .out_valid(out_valid6), .out_data(out_data6), .done(done6)
  );

  pool2x2_stream #(.m(2), .W(16)) u2 (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .in_valid(in_valid2), .in_data(in_data2),
    .out_valid(out_valid2), .out_data(out_data2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Scoreboard side: every pooled output is popped and compared the cycle it appears.
  always @(posedge clk) enPrev <= enable;

  always @(negedge clk) begin
    if (reset) begin
      if (!enPrev) checkOutput("enOffValid6", int'(out_valid6), 0);
      if (done6 && !out_valid6) checkOutput("doneAlone6", 1, 0);
      if (done2 && !out_valid2) checkOutput("doneAlone2", 1, 0);
      if (out_valid6) begin
        if (q6.size() == 0) checkOutput("unexpected6", int'(out_data6), 0 - 99999);
        else begin
          exp_t e;
          e = q6.pop_front();
          checkOutput("data6", int'(out_data6), e.data);
          checkOutput("done6", int'(done6), int'(e.last));
        end
      end
      if (out_valid2) begin
        if (q2.size() == 0) checkOutput("unexpected2", int'(out_data2), 0 - 99999);
        else begin
          exp_t e;
          e = q2.pop_front();
          checkOutput("data2", int'(out_data2), e.data);
          checkOutput("done2", int'(done2), int'(e.last));
        end
      end
    end
  end

  task automatic idle(input int n);
    in_valid6 = 1'b0;
    in_valid2 = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive6(input int x);
    in_valid6 = 1'b1;
    in_data6  = 16'(x);
    @(posedge clk);
    #1;
  endtask

  // Sends the first n samples of pix6; expects only windows whose bottom-right sample is sent.
  task automatic applyStimulus6(input int n, input bit gaps, input bit enStall);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        int tl;
        int s;
        exp_t e;
        tl = 12 * i + 2 * j;
        if (tl + 7 < n) begin
          s = pix6[tl] + pix6[tl + 1] + pix6[tl + 6] + pix6[tl + 7];
          e.data = s >>> 2;
          e.last = (i == 2 && j == 2);
          q6.push_back(e);
        end
      end
    end
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      if (enStall && k == 8) begin
        enable    = 1'b0;
        in_valid6 = 1'b1;
        in_data6  = 16'h7abc;
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        enable = 1'b1;
      end
      drive6(pix6[k]);
    end
  endtask

  task automatic applyStimulus2(input int a, input int b, input int c, input int d);
    exp_t e;
    int   v[4];
    e.data = (a + b + c + d) >>> 2;
    e.last = 1'b1;
    q2.push_back(e);
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int k = 0; k < 4; k++) begin
      in_valid2 = 1'b1;
      in_data2  = 16'(v[k]);
      @(posedge clk);
      #1;
    end
    in_valid2 = 1'b0;
  endtask

  task automatic fillRandom();
    for (int k = 0; k < 36; k++) pix6[k] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b0;
    enable    = 1'b1;
    clear     = 1'b0;
    in_valid6 = 1'b0;
    in_data6  = '0;
    in_valid2 = 1'b0;
    in_data2  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rstValid6", int'(out_valid6), 0);
    checkOutput("rstData6", int'(out_data6), 0);
    checkOutput("rstDone6", int'(done6), 0);
    checkOutput("rstValid2", int'(out_valid2), 0);
    checkOutput("rstData2", int'(out_data2), 0);
    checkOutput("rstDone2", int'(done2), 0);
    @(posedge clk);
    #1;

    $display("[TB] uniform frames");
    for (int k = 0; k < 36; k++) pix6[k] = 1024;
    applyStimulus6(36, 1'b0, 1'b0);
    applyStimulus6(36, 1'b0, 1'b0);
    idle(3);
    checkOutput("uniformDrain", q6.size(), 0);

    $display("[TB] m=2 mixed signs and extremes");
    applyStimulus2(1024, -2048, 3072, 5);
    applyStimulus2(-1, 0, 0, 0);
    applyStimulus2(32767, 32767, 32767, 32767);
    applyStimulus2(-32768, -32768, -32768, -32768);
    applyStimulus2(-3, -2, 1, 0);
    idle(3);
    checkOutput("m2Drain", q2.size(), 0);

    $display("[TB] stalls and enable low");
    fillRandom();
    applyStimulus6(36, 1'b1, 1'b1);
    fillRandom();
    applyStimulus6(36, 1'b1, 1'b0);
    idle(3);
    checkOutput("stallDrain", q6.size(), 0);

    $display("[TB] abort by reset");
    fillRandom();
    applyStimulus6(20, 1'b0, 1'b0);
    idle(2);
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    fillRandom();
    applyStimulus6(36, 1'b0, 1'b0);
    idle(3);
    checkOutput("abortRstDrain", q6.size(), 0);

    $display("[TB] abort by clear with colliding sample");
    fillRandom();
    applyStimulus6(20, 1'b0, 1'b0);
    clear     = 1'b1;
    in_valid6 = 1'b1;
    in_data6  = 16'h1234;
    @(posedge clk);
    #1;
    clear = 1'b0;
    fillRandom();
    applyStimulus6(36, 1'b0, 1'b0);
    idle(3);
    checkOutput("abortClrDrain", q6.size(), 0);
    checkOutput("finalDrain2", q2.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pool2x2_stream.md
# pool2x2_stream

Streaming 2x2 average-pooling stage directly downstream of the clocked image convolver. Consumes the convolver's row-major stream of signed 16-bit fixed-point results for one m x m feature map and emits the (m/2) x (m/2) pooled map, also row-major. Buffers one row of horizontal pair sums, so no frame memory is needed. Signals end of frame to the next layer.

## Interface

- m, default 6: feature-map side length (conv output of a 10x10 image with a 5x5 filter); must be even and >= 2.
- W, default 16: sample width, signed two's complement, same fixed-point format as the convolver.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; state clears while 0.
- enable  in  1  when 0, in_valid is ignored and all state holds; out_valid and done are forced 0 that cycle.
- clear  in  1  synchronous frame restart; counters return to 0 and the held pair is discarded; has priority over in_valid.
- in_valid  in  1  in_data carries the next convolved sample.
- in_data  in  W  signed convolved sample.
- out_valid  out  1  out_data holds a pooled sample for exactly this cycle.
- out_data  out  W  signed pooled sample.
- done  out  1  one-cycle pulse coincident with the last out_valid of a frame.

## Operation

- Input is accepted on a rising clk edge when reset=1, enable=1, clear=0 and in_valid=1. There is no backpressure. The downstream stage must take every out_valid.
- The block keeps a row counter r (0..m-1) and a column counter c (0..m-1). c increments on each accepted sample. At c=m-1, c wraps to 0 and r increments. At r=m-1 and c=m-1, both wrap to 0 and the next frame starts with no gap.
- The block holds a register `hold` (W bits) and a line buffer lb[0..m/2-1] (W+1 bits each).
- Even r, even c: hold <= x.
- Even r, odd c: lb[c/2] <= hold + x, with sign extension to W+1.
- Odd r, even c: hold <= x.
- Odd r, odd c: sum = lb[c/2] + hold + x in W+2 bits. out_data <= sum >>> 2, which is an arithmetic shift and floors toward negative infinity. out_valid <= 1.
- The shifted result always fits in W bits, so no saturation logic is needed.
- Pooled outputs leave in row-major order: (m/2)^2 per frame.
- done <= 1 on the same edge that registers the output for r=m-1, c=m-1.
- clear, or reset asserted mid-frame, abandons the partial frame and emits no output for it. The line buffer need not be zeroed, because every entry is rewritten before it is read.
- Reset values: out_valid=0, out_data=0, done=0, r=0, c=0, hold=0.

## Timing

- Latency is 1 cycle: out_valid goes high in the cycle after the edge that accepted the bottom-right sample of a 2x2 window.
- Back-to-back input at full rate for m=6 gives 36 input cycles per frame and 9 outputs. Outputs appear on the odd rows, one every 2 cycles.
- Gaps in in_valid stall the counters only; results are identical to gap-free input.
- If clear and in_valid are both high, the sample is dropped and the counters go to 0.
- If enable is low, in_valid is ignored that cycle.
- out_valid, out_data and done all update only on an accepting edge; on any other edge out_valid=0 and done=0.

## Test plan

- Reset with reset=0 for 2 cycles, then release: all outputs are 0.
- Uniform frame, m=6, all samples 1024 (1.0), streamed back to back: exactly 9 out_valid pulses, each out_data=1024. done is high only with the 9th pulse. A second identical frame follows immediately with the same result.
- Mixed signs, m=2, samples 1024, -2048, 3072, 5: sum is 2053, so out_data=513. Samples -1, 0, 0, 0: out_data=-1 (floor, not truncation toward zero).
- Extremes, m=2: four samples of 32767 give 32767. Four samples of -32768 give -32768. No wrap in either case.
- Stalls, m=6, with random in_valid gaps and enable low for 3 cycles mid-row: the output sequence matches the gap-free reference model, and no output appears while enable=0.
- Abort and restart: assert reset=0 (or clear=1) after 20 samples of a frame, then send a fresh 36-sample frame. Exactly 9 correct outputs and one done result; nothing from the aborted frame appears.
